// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared core types and helpers: result widths, the CDB result
//                record and ROB-relative age arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

   localparam int TAG_W  = 8;
   localparam int DATA_W = 32;
   localparam int ROB_W  = 7;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [DATA_W-1:0] data;
      logic [ROB_W-1:0]  rob_tag;
   } cdb_result_t;

   // Distance of a ROB entry from the current ROB head; larger means younger.
   function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                                input logic [ROB_W-1:0] head);
      return tag - head;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rob_age_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : rob_age_cmp
//  Description : Combinational ROB-age comparator; o_younger is set when i_a
//                is strictly younger than i_b relative to the ROB head.
//  Revision    : 1.0 - initial release
// ============================================================================
module rob_age_cmp #(
   parameter int ROB_W = core_pkg::ROB_W
) (
   input  logic [ROB_W-1:0] i_a,
   input  logic [ROB_W-1:0] i_b,
   input  logic [ROB_W-1:0] i_head,
   output logic             o_younger
);

   logic [ROB_W-1:0] w_age_a;
   logic [ROB_W-1:0] w_age_b;

   // Ages wrap modulo the ROB size, so subtract the head before comparing.
   always_comb begin
      w_age_a   = i_a - i_head;
      w_age_b   = i_b - i_head;
      o_younger = (w_age_a > w_age_b);
   end

endmodule
`default_nettype wire

// File: rtl/fu_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fu_result_queue
//  Description : Per-functional-unit result buffer feeding the CDB arbiter.
//                Circular buffer with live bits supporting full flush and
//                selective squash of entries younger than a branch.
//  Revision    : 1.0 - initial release
// ============================================================================
module fu_result_queue #(
   parameter int DEPTH     = 4,
   parameter int TAG_W     = core_pkg::TAG_W,
   parameter int DATA_W    = core_pkg::DATA_W,
   parameter int ROB_W     = core_pkg::ROB_W,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [TAG_W-1:0]         in_tag,
   input  logic [DATA_W-1:0]        in_data,
   input  logic [ROB_W-1:0]         in_rob_tag,
   output logic                     out_valid,
   output logic [TAG_W-1:0]         out_tag,
   output logic [DATA_W-1:0]        out_data,
   output logic [ROB_W-1:0]         out_rob_tag,
   input  logic                     out_grant,
   input  logic                     flush_all,
   input  logic                     squash_valid,
   input  logic [ROB_W-1:0]         squash_rob_tag,
   input  logic [ROB_W-1:0]         rob_head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full
);

   localparam int                 c_ptr_w = $clog2(DEPTH);
   localparam int                 c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(DEPTH);
   localparam logic [c_cnt_w-1:0] c_afull = c_cnt_w'(AFULL_LVL);

   logic [TAG_W-1:0]   r_tag  [DEPTH];
   logic [DATA_W-1:0]  r_data [DEPTH];
   logic [ROB_W-1:0]   r_rob  [DEPTH];
   logic [DEPTH-1:0]   r_live;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_cnt_w-1:0] r_count;

   logic               w_nonempty;
   logic               w_head_live;
   logic               w_out_valid;
   logic               w_push;
   logic               w_pop;
   logic               w_push_dead;
   logic               w_in_younger;
   logic [DEPTH-1:0]   w_younger;

   assign w_nonempty  = (r_count != '0);
   assign w_head_live = r_live[r_rd_ptr];
   assign w_out_valid = w_nonempty && w_head_live;
   // A full queue refuses input even when the head is granted this cycle.
   assign in_ready    = (r_count < c_full);
   assign w_push      = in_valid && in_ready && !flush_all;
   // A dead head drains on its own; a live head leaves only when granted.
   assign w_pop       = w_nonempty && (!w_head_live || out_grant);
   assign w_push_dead = squash_valid && w_in_younger;

   assign out_valid   = w_out_valid;
   assign out_tag     = w_out_valid ? r_tag[r_rd_ptr]  : '0;
   assign out_data    = w_out_valid ? r_data[r_rd_ptr] : '0;
   assign out_rob_tag = w_out_valid ? r_rob[r_rd_ptr]  : '0;
   assign count       = r_count;
   assign almost_full = (r_count >= c_afull);

   // One age comparator per stored entry against the mispredicted branch.
   generate
      for (genvar i = 0; i < DEPTH; i++) begin : g_age_cmp
         rob_age_cmp #(.ROB_W(ROB_W)) u_cmp (
            .i_a       (r_rob[i]),
            .i_b       (squash_rob_tag),
            .i_head    (rob_head),
            .o_younger (w_younger[i])
         );
      end
   endgenerate

   // Incoming result is checked too, so a younger push lands already dead.
   rob_age_cmp #(.ROB_W(ROB_W)) u_in_cmp (
      .i_a       (in_rob_tag),
      .i_b       (squash_rob_tag),
      .i_head    (rob_head),
      .o_younger (w_in_younger)
   );

   // Pointer and occupancy tracking; flush returns everything to empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush_all) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Live bits: squash kills younger entries, pop retires, push installs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_live <= '0;
      end else if (flush_all) begin
         r_live <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (squash_valid && w_younger[i]) r_live[i] <= 1'b0;
         end
         if (w_pop)  r_live[r_rd_ptr] <= 1'b0;
         if (w_push) r_live[r_wr_ptr] <= !w_push_dead;
      end
   end

   // Payload storage; contents are meaningful only while the live bit is set.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_tag[r_wr_ptr]  <= in_tag;
         r_data[r_wr_ptr] <= in_data;
         r_rob[r_wr_ptr]  <= in_rob_tag;
      end
   end

`ifndef SYNTHESIS
   a_count_max: assert property (@(posedge clk) disable iff (reset)
      r_count <= c_full);
   a_no_push_full: assert property (@(posedge clk) disable iff (reset)
      w_push |-> (r_count != c_full));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_result_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fu_result_queue
//  Description : Directed scoreboard bench for fu_result_queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fu_result_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_tag;
   logic [31:0] in_data;
   logic [6:0]  in_rob_tag;
   logic        out_valid;
   logic [7:0]  out_tag;
   logic [31:0] out_data;
   logic [6:0]  out_rob_tag;
   logic        out_grant;
   logic        flush_all;
   logic        squash_valid;
   logic [6:0]  squash_rob_tag;
   logic [6:0]  rob_head;
   logic [2:0]  count;
   logic        almost_full;

   typedef struct {
      logic [7:0]  tag;
      logic [31:0] data;
      logic [6:0]  rob;
      bit          live;
   } ent_t;

   ent_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   fu_result_queue #(.DEPTH(DEPTH), .TAG_W(8), .DATA_W(32), .ROB_W(7), .AFULL_LVL(DEPTH-1)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
      .in_rob_tag(in_rob_tag),
      .out_valid(out_valid), .out_tag(out_tag), .out_data(out_data), .out_rob_tag(out_rob_tag),
      .out_grant(out_grant), .flush_all(flush_all),
      .squash_valid(squash_valid), .squash_rob_tag(squash_rob_tag), .rob_head(rob_head),
      .count(count), .almost_full(almost_full)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [6:0] age(input logic [6:0] x, input logic [6:0] h);
      return x - h;
   endfunction

   // Compare every DUT output against the scoreboard contents.
   task automatic check_outputs();
      bit exp_valid;
      exp_valid = 1'b0;
      if (sb.size() != 0) exp_valid = sb[0].live;
      chk("count",       64'(count),       64'(sb.size()));
      chk("in_ready",    64'(in_ready),    64'(sb.size() < DEPTH));
      chk("almost_full", 64'(almost_full), 64'(sb.size() >= DEPTH - 1));
      chk("out_valid",   64'(out_valid),   64'(exp_valid));
      if (exp_valid) begin
         chk("out_tag",     64'(out_tag),     64'(sb[0].tag));
         chk("out_data",    64'(out_data),    64'(sb[0].data));
         chk("out_rob_tag", 64'(out_rob_tag), 64'(sb[0].rob));
      end else begin
         chk("out_tag_idle",  64'(out_tag),  64'h0);
         chk("out_data_idle", 64'(out_data), 64'h0);
      end
   endtask

   // Check outputs before the edge, advance the model, then cross the edge.
   task automatic step();
      bit   do_push;
      bit   do_pop;
      ent_t e;
      #3;
      check_outputs();
      if (flush_all) begin
         sb.delete();
      end else begin
         do_push = in_valid && (sb.size() < DEPTH);
         do_pop  = 1'b0;
         if (sb.size() != 0) do_pop = !sb[0].live || out_grant;
         if (do_pop) void'(sb.pop_front());
         if (squash_valid) begin
            foreach (sb[k]) begin
               if (age(sb[k].rob, rob_head) > age(squash_rob_tag, rob_head)) sb[k].live = 1'b0;
            end
         end
         if (do_push) begin
            e.tag  = in_tag;
            e.data = in_data;
            e.rob  = in_rob_tag;
            e.live = !(squash_valid && (age(in_rob_tag, rob_head) > age(squash_rob_tag, rob_head)));
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [7:0] t, input logic [31:0] d, input logic [6:0] r);
      in_valid   = v;
      in_tag     = t;
      in_data    = d;
      in_rob_tag = r;
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      out_grant = 1'b0; flush_all = 1'b0; squash_valid = 1'b0;
      squash_rob_tag = 7'h0; rob_head = 7'h0;
      #12;
      check_outputs();
      @(posedge clk); #1;
      reset = 1'b0;

      // In-order delivery of three back-to-back pushes.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'(8'h11 * (i + 1)), 32'hA000_0000 + 32'(i), 7'(i + 1));
         step();
      end
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      chk("t1_count3", 64'(count), 64'd3);
      out_grant = 1'b1;
      for (int i = 0; i < 3; i++) step();
      out_grant = 1'b0;
      step();

      // Fill to full, then stream with grant held.
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h40 + 8'(i), 32'hB000_0000 + 32'(i), 7'(10 + i));
         step();
      end
      chk("t2_full_ready", 64'(in_ready), 64'd0);
      out_grant = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 8'h50 + 8'(i), 32'hC000_0000 + 32'(i), 7'(20 + i));
         step();
      end
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      for (int i = 0; i < 8 && sb.size() != 0; i++) step();
      out_grant = 1'b0;
      step();

      // Squash across the ROB wrap point.
      rob_head = 7'd120;
      drive(1'b1, 8'h61, 32'hD000_0001, 7'd122); step();
      drive(1'b1, 8'h62, 32'hD000_0002, 7'd125); step();
      drive(1'b1, 8'h63, 32'hD000_0003, 7'd2);   step();
      drive(1'b1, 8'h64, 32'hD000_0004, 7'd5);   step();
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      squash_valid = 1'b1; squash_rob_tag = 7'd125;
      step();
      squash_valid = 1'b0;
      out_grant = 1'b1;
      for (int i = 0; i < 4; i++) step();
      out_grant = 1'b0;
      chk("t3_drained", 64'(count), 64'd0);
      step();

      // Same-cycle push younger than the squashing branch lands dead.
      rob_head = 7'd8;
      drive(1'b1, 8'h91, 32'hE000_0009, 7'd9); step();
      drive(1'b1, 8'hBB, 32'hE000_000B, 7'd11);
      squash_valid = 1'b1; squash_rob_tag = 7'd10;
      step();
      squash_valid = 1'b0;
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      chk("t4_count2", 64'(count), 64'd2);
      step();
      out_grant = 1'b1;
      step(); step();
      out_grant = 1'b0;
      step();

      // Flush overrides a same-cycle push and grant.
      rob_head = 7'd0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 8'h71 + 8'(i), 32'hF000_0000 + 32'(i), 7'(30 + i));
         step();
      end
      drive(1'b1, 8'hEE, 32'hDEAD_BEEF, 7'd40);
      out_grant = 1'b1; flush_all = 1'b1;
      step();
      flush_all = 1'b0; out_grant = 1'b0;
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      chk("t5_count0", 64'(count), 64'd0);
      step();

      // Asynchronous reset between edges empties the queue at once.
      drive(1'b1, 8'h81, 32'h0000_0081, 7'd1); step();
      drive(1'b1, 8'h82, 32'h0000_0082, 7'd2); step();
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      #2;
      reset = 1'b1;
      #1;
      sb.delete();
      chk("t6_async_count", 64'(count), 64'd0);
      chk("t6_async_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      drive(1'b1, 8'h99, 32'h0000_0099, 7'd3); step();
      drive(1'b0, 8'h0, 32'h0, 7'h0);
      out_grant = 1'b1;
      step();
      out_grant = 1'b0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
